// File: rtl/flex_updown_counter_if.sv
// Control and status bundle for flex_updown_counter.
// The master drives the controls and the slave (the counter) drives the status.
interface flex_updown_counter_if #(
  parameter int NUM_BITS = 4
) ();
  logic                clear;
  logic                load;
  logic [NUM_BITS-1:0] load_val;
  logic                count_enable;
  logic                count_up;
  logic                sat_mode;
  logic [NUM_BITS-1:0] rollover_val;
  logic [NUM_BITS-1:0] count_out;
  logic                rollover_flag;
  logic                bottom_flag;
  logic                wrap_pulse;

  modport master (
    output clear, load, load_val, count_enable, count_up, sat_mode, rollover_val,
    input  count_out, rollover_flag, bottom_flag, wrap_pulse
  );

  modport slave (
    input  clear, load, load_val, count_enable, count_up, sat_mode, rollover_val,
    output count_out, rollover_flag, bottom_flag, wrap_pulse
  );
endinterface

// File: rtl/flex_updown_counter.sv
// Up/down counter over the range 1..rollover_val with parallel load and wrap/saturate.
// The flags are registered from the next count, so they line up with count_out.
module flex_updown_counter #(
  parameter int NUM_BITS = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  flex_updown_counter_if.slave  bus
);
  localparam logic [NUM_BITS-1:0] ONE  = NUM_BITS'(1);
  localparam logic [NUM_BITS-1:0] ZERO = NUM_BITS'(0);

  logic [NUM_BITS-1:0] count_q, count_d;
  logic                rollover_q, rollover_d;
  logic                bottom_q, bottom_d;
  logic                wrap_q, wrap_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      count_d = ZERO;
    end else if (bus.load) begin
      count_d = bus.load_val;
    end else if (bus.count_enable) begin
      // A zero terminal value freezes stepping; otherwise both limits would wrap to 0 or 1.
      if (bus.rollover_val == ZERO) begin
        count_d = count_q;
      end else if (bus.count_up) begin
        if (count_q >= bus.rollover_val) begin
          if (bus.sat_mode) begin
            count_d = count_q;
          end else begin
            count_d = ONE;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q <= ONE) begin
          if (bus.sat_mode) begin
            count_d = count_q;
          end else begin
            count_d = bus.rollover_val;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - ONE;
        end
      end
    end else begin
      count_d = count_q;
    end
    rollover_d = (count_d == bus.rollover_val);
    bottom_d   = (count_d == ONE);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q    <= ZERO;
      rollover_q <= 1'b0;
      bottom_q   <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      rollover_q <= rollover_d;
      bottom_q   <= bottom_d;
      wrap_q     <= wrap_d;
    end
  end

  assign bus.count_out     = count_q;
  assign bus.rollover_flag = rollover_q;
  assign bus.bottom_flag   = bottom_q;
  assign bus.wrap_pulse    = wrap_q;
endmodule

// File: tb/tb_flex_updown_counter.sv
// Directed bench for flex_updown_counter: a 4-bit instance for the main behaviour
// and an 8-bit instance for the top-of-range wrap.
module tb_flex_updown_counter;
  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  flex_updown_counter_if #(.NUM_BITS(4)) if_a ();
  flex_updown_counter_if #(.NUM_BITS(8)) if_b ();

  flex_updown_counter #(.NUM_BITS(4)) dut_a (.clk(clk), .n_rst(n_rst), .bus(if_a));
  flex_updown_counter #(.NUM_BITS(8)) dut_b (.clk(clk), .n_rst(n_rst), .bus(if_b));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic expect_a(input string tag, input int cnt, input bit rf, input bit bf, input bit wp);
    check_eq({tag, ".cnt"}, 32'(if_a.count_out), 32'(cnt));
    check_eq({tag, ".rf"},  32'(if_a.rollover_flag), 32'(rf));
    check_eq({tag, ".bf"},  32'(if_a.bottom_flag), 32'(bf));
    check_eq({tag, ".wp"},  32'(if_a.wrap_pulse), 32'(wp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_rst = 1'b0;
    if_a.clear = 1'b0; if_a.load = 1'b0; if_a.load_val = 4'd0; if_a.count_enable = 1'b0;
    if_a.count_up = 1'b1; if_a.sat_mode = 1'b0; if_a.rollover_val = 4'd5;
    if_b.clear = 1'b0; if_b.load = 1'b0; if_b.load_val = 8'd0; if_b.count_enable = 1'b0;
    if_b.count_up = 1'b1; if_b.sat_mode = 1'b0; if_b.rollover_val = 8'd255;
    tick();
    expect_a("reset0", 0, 1'b0, 1'b0, 1'b0);
    check_eq("reset0_b.cnt", 32'(if_b.count_out), 32'd0);
    n_rst = 1'b1;

    // Up wrap at 5
    if_a.count_enable = 1'b1;
    tick(); expect_a("up1", 1, 1'b0, 1'b1, 1'b0);
    tick(); expect_a("up2", 2, 1'b0, 1'b0, 1'b0);
    tick(); expect_a("up3", 3, 1'b0, 1'b0, 1'b0);
    tick(); expect_a("up4", 4, 1'b0, 1'b0, 1'b0);
    tick(); expect_a("up5", 5, 1'b1, 1'b0, 1'b0);
    tick(); expect_a("upwrap", 1, 1'b0, 1'b1, 1'b1);
    tick(); expect_a("up2b", 2, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    expect_a("at5", 5, 1'b1, 1'b0, 1'b0);
    if_a.count_enable = 1'b0;

    // Synchronous reset: no effect between edges
    n_rst = 1'b0;
    #3;
    check_eq("rst_no_async", 32'(if_a.count_out), 32'd5);
    tick(); expect_a("rst_sync", 0, 1'b0, 1'b0, 1'b0);
    n_rst = 1'b1;
    if_a.load = 1'b1; if_a.load_val = 4'd5;
    tick(); expect_a("load5", 5, 1'b1, 1'b0, 1'b0);
    if_a.load = 1'b0; if_a.clear = 1'b1;
    tick(); expect_a("clear", 0, 1'b0, 1'b0, 1'b0);
    if_a.clear = 1'b0;

    // Down wrap then saturate with rollover 4
    if_a.rollover_val = 4'd4; if_a.load = 1'b1; if_a.load_val = 4'd2;
    tick(); expect_a("ld2", 2, 1'b0, 1'b0, 1'b0);
    if_a.load = 1'b0; if_a.count_enable = 1'b1; if_a.count_up = 1'b0;
    tick(); expect_a("dn1", 1, 1'b0, 1'b1, 1'b0);
    tick(); expect_a("dnwrap", 4, 1'b1, 1'b0, 1'b1);
    tick(); expect_a("dn3", 3, 1'b0, 1'b0, 1'b0);
    if_a.count_enable = 1'b0; if_a.load = 1'b1; if_a.sat_mode = 1'b1;
    tick(); expect_a("ld2s", 2, 1'b0, 1'b0, 1'b0);
    if_a.load = 1'b0; if_a.count_enable = 1'b1;
    tick(); expect_a("sat1", 1, 1'b0, 1'b1, 1'b0);
    tick(); expect_a("sat2", 1, 1'b0, 1'b1, 1'b0);
    tick(); expect_a("sat3", 1, 1'b0, 1'b1, 1'b0);
    if_a.count_enable = 1'b0; if_a.sat_mode = 1'b0;

    // Priority
    if_a.rollover_val = 4'd5; if_a.count_up = 1'b1;
    if_a.clear = 1'b1; if_a.load = 1'b1; if_a.load_val = 4'd9; if_a.count_enable = 1'b1;
    tick(); expect_a("pri_clr", 0, 1'b0, 1'b0, 1'b0);
    if_a.clear = 1'b0;
    tick(); expect_a("pri_ld", 9, 1'b0, 1'b0, 1'b0);
    if_a.load = 1'b0;
    tick(); expect_a("oor_wrap", 1, 1'b0, 1'b1, 1'b1);
    if_a.count_enable = 1'b0;

    // Saturate at top while counting up
    if_a.load = 1'b1; if_a.load_val = 4'd5;
    tick();
    if_a.load = 1'b0; if_a.sat_mode = 1'b1; if_a.count_enable = 1'b1;
    tick(); expect_a("sat_top", 5, 1'b1, 1'b0, 1'b0);
    if_a.sat_mode = 1'b0; if_a.count_enable = 1'b0;

    // Degenerate rollover_val = 0
    if_a.clear = 1'b1;
    tick();
    if_a.clear = 1'b0; if_a.rollover_val = 4'd0; if_a.count_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); expect_a("rv0_up", 0, 1'b1, 1'b0, 1'b0);
    end
    if_a.count_up = 1'b0;
    tick(); expect_a("rv0_dn", 0, 1'b1, 1'b0, 1'b0);
    if_a.count_enable = 1'b0; if_a.count_up = 1'b1;

    // Dynamic rollover_val
    if_a.rollover_val = 4'd6; if_a.load = 1'b1; if_a.load_val = 4'd5;
    tick();
    if_a.load = 1'b0; if_a.count_enable = 1'b1;
    tick(); expect_a("dyn6", 6, 1'b1, 1'b0, 1'b0);
    if_a.rollover_val = 4'd3;
    tick(); expect_a("dyn_wrap", 1, 1'b0, 1'b1, 1'b1);
    if_a.count_enable = 1'b0; if_a.load = 1'b1; if_a.load_val = 4'd6;
    tick(); expect_a("dyn_ld6", 6, 1'b0, 1'b0, 1'b0);
    if_a.load = 1'b0; if_a.rollover_val = 4'd6;
    #1;
    check_eq("dyn_rf_late", 32'(if_a.rollover_flag), 32'd0);
    tick(); expect_a("dyn_rf_rise", 6, 1'b1, 1'b0, 1'b0);
    if_a.rollover_val = 4'd3; if_a.count_up = 1'b0; if_a.count_enable = 1'b1;
    tick(); expect_a("oor_down", 5, 1'b0, 1'b0, 1'b0);
    if_a.count_enable = 1'b0;

    // 8-bit top-of-range wrap
    if_b.load = 1'b1; if_b.load_val = 8'd254;
    tick();
    check_eq("b_ld.cnt", 32'(if_b.count_out), 32'd254);
    if_b.load = 1'b0; if_b.count_enable = 1'b1;
    tick();
    check_eq("b_255.cnt", 32'(if_b.count_out), 32'd255);
    check_eq("b_255.rf", 32'(if_b.rollover_flag), 32'd1);
    tick();
    check_eq("b_wrap.cnt", 32'(if_b.count_out), 32'd1);
    check_eq("b_wrap.wp", 32'(if_b.wrap_pulse), 32'd1);
    check_eq("b_wrap.bf", 32'(if_b.bottom_flag), 32'd1);
    if_b.count_enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/flex_updown_counter.md
Name: flex_updown_counter

Overview:
Parametrised up/down counter with programmable terminal value, parallel load, and a run-time wrap/saturate mode. It is the next generation of the team's flex counter and serves as the general-purpose bit/byte/timer counter in the lab datapaths. Count range is 1..rollover_val. All outputs are registered.

Parameters:
NUM_BITS, 4, width of count_out, load_val and rollover_val (legal range 2..32).

Ports:
clk  input  1  system clock, rising-edge.
n_rst  input  1  reset, synchronous, active-low.
clear  input  1  synchronous clear to 0.
load  input  1  parallel load of load_val.
load_val  input  NUM_BITS  value written on load.
count_enable  input  1  advance one step this cycle.
count_up  input  1  direction: 1 = up, 0 = down.
sat_mode  input  1  0 = wrap at limits, 1 = saturate (hold) at limits.
rollover_val  input  NUM_BITS  terminal (top) count value.
count_out  output  NUM_BITS  current count.
rollover_flag  output  1  high while count_out == rollover_val.
bottom_flag  output  1  high while count_out == 1.
wrap_pulse  output  1  one-cycle pulse in the cycle after a wrap occurred.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. The clock port is clk and the reset port is n_rst. With n_rst low at a rising edge: count_out = 0, rollover_flag = 0, bottom_flag = 0, wrap_pulse = 0. Reset is sampled only on clk edges.
- Priority per edge: n_rst low > clear > load > count_enable > hold.
- clear: count_out <= 0. Flags are then recomputed from 0, so both flags are 0 unless rollover_val == 0. wrap_pulse <= 0.
- load: count_out <= load_val unmodified, with no clamping. wrap_pulse <= 0.
- Enable, up (count_up = 1):
  - if count_out >= rollover_val (terminal): sat_mode = 0 -> count_out <= 1, wrap event; sat_mode = 1 -> hold.
  - else count_out <= count_out + 1.
- Enable, down (count_up = 0):
  - if count_out <= 1 (includes 0 after clear): sat_mode = 0 -> count_out <= rollover_val, wrap event; sat_mode = 1 -> hold.
  - else count_out <= count_out - 1.
- Out-of-range start: a loaded value > rollover_val is terminal when counting up, so the next up step wraps to 1 or saturates. Counting down from it decrements normally.
- rollover_val == 0: count_enable has no effect on count_out and no wrap event occurs. clear and load still work.
- Flags are registered from next-state:
  - rollover_flag <= (next_count == rollover_val).
  - bottom_flag <= (next_count == 1).
  - Both are computed against the rollover_val present at the same edge. A change of rollover_val while idle updates rollover_flag on the next edge.
- wrap_pulse <= 1 exactly on the edge where a wrap event updates count_out, and 0 on every other edge. Saturated holds never pulse.
- Direction or sat_mode may change on any cycle; each edge uses the values sampled at that edge only. No internal state beyond count_out and the three flag registers.
- Arithmetic is modulo 2^NUM_BITS but is never reached: increments occur only below rollover_val, decrements only above 1.
- Simultaneous events: clear+load -> clear wins. load+count_enable -> load wins, with no step applied.

Test Plan:
- Reset/clear: NUM_BITS=4, count to 5, drive n_rst=0 for 1 cycle (no async effect between edges) -> count_out=0, all flags 0 after edge. Repeat with clear=1 -> same.
- Up wrap: rollover_val=5, sat_mode=0, enable 7 cycles from 0 -> 1,2,3,4,5,1,2. rollover_flag high only while 5. wrap_pulse high only the cycle count_out first reads 1 after 5.
- Down wrap and saturate: rollover_val=4, load 2, down, sat_mode=0, 3 enables -> 1,4,3 with wrap_pulse at 4. Then load 2 with sat_mode=1, 3 enables -> 1,1,1, no wrap_pulse.
- Priority: clear=load=count_enable=1 with load_val=9 -> 0. load=count_enable=1, load_val=9 -> 9. Next up enable with rollover_val=5 -> 1 plus wrap_pulse.
- Degenerate and limits: rollover_val=0 with enable for 4 cycles -> count_out stays 0, rollover_flag=1. NUM_BITS=8, rollover_val=255, up from 254 -> 255 then 1.
- Dynamic rollover_val: counting at 6, lower rollover_val to 3 -> next up step gives 1 (wrap). Raise rollover_val to 6 while idle at 6 -> rollover_flag rises one edge later.
